// File: rtl/stack_mem_arbiter.sv
// Round-robin req/ack arbiter sharing one single-port memory between the CPU and debug ports.
// Optional debug bus lock enabled by defining ARB_DBG_LOCK_EN (adds the d_lock input).
module stack_mem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
`ifdef ARB_DBG_LOCK_EN
  input  logic          d_lock,
`endif
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last;
  logic       lock_eff;
  logic       grant;
  logic       win_d;
  logic       capture;

`ifdef ARB_DBG_LOCK_EN
  logic lock;

  // Lock is only honoured while d_lock stays high; a low d_lock in IDLE releases it.
  assign lock_eff = lock & d_lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock <= 1'b0;
    end else if (state == RESP && owner && d_lock) begin
      lock <= 1'b1;
    end else if (state == IDLE && !d_lock) begin
      lock <= 1'b0;
    end
  end
`else
  assign lock_eff = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win_d     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (lock_eff) begin
          grant = d_req;
          win_d = 1'b1;
        end else begin
          grant = c_req | d_req;
          win_d = d_req & (~c_req | ~last);
        end
        if (grant) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      c_rdata <= '0;
      d_rdata <= '0;
    end else begin
      m_en  <= 1'b0;
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant) begin
        owner   <= win_d;
        m_en    <= 1'b1;
        m_we    <= win_d ? d_we    : c_we;
        m_addr  <= win_d ? d_addr  : c_addr;
        m_wdata <= win_d ? d_wdata : c_wdata;
        cnt     <= 4'(MEM_LAT - 1);
      end
      if (state == ACCESS && !capture) cnt <= cnt - 4'd1;
      // Read data lands in the winner's register only; writes keep the old value.
      if (capture) begin
        if (!m_we) begin
          if (owner) d_rdata <= m_rdata;
          else       c_rdata <= m_rdata;
        end
        if (owner) d_ack <= 1'b1;
        else       c_ack <= 1'b1;
      end
      if (state == RESP) last <= owner;
    end
  end

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Directed bench for stack_mem_arbiter: MEM_LAT=1 instance for most cases, MEM_LAT=3 for latency.
module tb_stack_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       c_req, c_we, d_req, d_we;
  logic [4:0] c_addr, d_addr, m_addr;
  logic [7:0] c_wdata, d_wdata, c_rdata, d_rdata, m_wdata, m_rdata;
  logic       c_ack, d_ack, m_en, m_we, busy, owner;

  logic       d_req3;
  logic [4:0] d_addr3, m_addr3;
  logic [7:0] c_rdata3, d_rdata3, m_wdata3, m_rdata3;
  logic       c_ack3, d_ack3, m_en3, m_we3, busy3, owner3;
  logic [3:0] age3 = 4'd0;
  int         en3_cnt = 0;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;

`ifdef ARB_DBG_LOCK_EN
  logic d_lock;
  logic d_lock3;
`endif

  always #5 clk = ~clk;

  stack_mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef ARB_DBG_LOCK_EN
    .d_lock(d_lock),
`endif
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  stack_mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .c_req(1'b0), .c_we(1'b0), .c_addr(5'd0), .c_wdata(8'd0),
    .c_ack(c_ack3), .c_rdata(c_rdata3),
    .d_req(d_req3), .d_we(1'b0), .d_addr(d_addr3), .d_wdata(8'd0),
`ifdef ARB_DBG_LOCK_EN
    .d_lock(d_lock3),
`endif
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
    .busy(busy3), .owner(owner3)
  );

  // Latency-1 memory answers in the command cycle; the latency-3 one only two cycles later.
  assign m_rdata  = mem[m_addr];
  assign m_rdata3 = (age3 == 4'd2) ? mem[m_addr3] : 8'hEE;

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en3) begin
      age3    <= 4'd1;
      en3_cnt <= en3_cnt + 1;
    end else if (age3 != 4'd0 && age3 < 4'd8) begin
      age3 <= age3 + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
      chk("ack_excl", {31'd0, c_ack & d_ack}, 32'd0);
    end while (!(c_ack || d_ack) && n < 8);
  endtask

  int n;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[3] = 8'hA5;
    mem[7] = 8'h77;
    mem[9] = 8'h99;
    rst = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_req3 = 0; d_addr3 = 0;
`ifdef ARB_DBG_LOCK_EN
    d_lock = 0; d_lock3 = 0;
`endif
    repeat (2) tick();
    chk("rst_acks", {30'd0, c_ack, d_ack}, 32'd0);
    chk("rst_rdata", {16'd0, c_rdata, d_rdata}, 32'd0);
    chk("rst_mcmd", {18'd0, m_en, m_we, m_addr, m_wdata}, 32'd0);
    chk("rst_busy_owner", {30'd0, busy, owner}, 32'd0);
    rst = 1'b1;

    // CPU read of address 03
    c_req = 1; c_we = 0; c_addr = 5'h03;
    tick();
    chk("t1_men", {31'd0, m_en}, 1);
    chk("t1_mwe", {31'd0, m_we}, 0);
    chk("t1_maddr", m_addr, 5'h03);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_cack_early", {31'd0, c_ack}, 0);
    tick();
    chk("t1_cack", {31'd0, c_ack}, 1);
    chk("t1_crdata", c_rdata, 8'hA5);
    chk("t1_dack", {31'd0, d_ack}, 0);
    chk("t1_men_once", {31'd0, m_en}, 0);
    c_req = 0;
    tick();
    chk("t1_idle", {30'd0, busy, c_ack}, 0);
    chk("t1_hold", c_rdata, 8'hA5);

    // Debug write 1F <= 3C, then CPU read 1F
    d_req = 1; d_we = 1; d_addr = 5'h1F; d_wdata = 8'h3C;
    tick();
    chk("t3_men", {31'd0, m_en}, 1);
    chk("t3_mwe", {31'd0, m_we}, 1);
    chk("t3_mwdata", m_wdata, 8'h3C);
    chk("t3_maddr", m_addr, 5'h1F);
    chk("t3_owner", {31'd0, owner}, 1);
    tick();
    chk("t3_dack", {31'd0, d_ack}, 1);
    chk("t3_drdata_kept", d_rdata, 8'h00);
    d_req = 0; d_we = 0;
    tick();
    c_req = 1; c_we = 0; c_addr = 5'h1F;
    tick();
    chk("t3_rd_men", {31'd0, m_en}, 1);
    chk("t3_rd_owner", {31'd0, owner}, 0);
    tick();
    chk("t3_cack", {31'd0, c_ack}, 1);
    chk("t3_crdata", c_rdata, 8'h3C);
    chk("t3_drdata", d_rdata, 8'h00);
    c_req = 0;
    tick();

    // Reset during ACCESS of a CPU read
    c_req = 1; c_we = 0; c_addr = 5'h05;
    tick();
    chk("t4_men", {31'd0, m_en}, 1);
    rst = 1'b0;
    #1;
    chk("t4_mcmd", {18'd0, m_en, m_we, m_addr, m_wdata}, 32'd0);
    chk("t4_busy_owner", {30'd0, busy, owner}, 32'd0);
    chk("t4_crdata", c_rdata, 8'h00);
    tick();
    chk("t4_noack", {30'd0, c_ack, d_ack}, 32'd0);
    c_req = 0;
    rst = 1'b1;
    tick();

    // Both ports requesting: C,D,C,D with acks 3 cycles apart
    c_req = 1; c_we = 0; c_addr = 5'h03;
    d_req = 1; d_we = 0; d_addr = 5'h07;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      chk("t2_gap", n, (k == 0) ? 2 : 3);
      chk("t2_cack", {31'd0, c_ack}, (k % 2 == 0) ? 1 : 0);
      chk("t2_dack", {31'd0, d_ack}, (k % 2 == 1) ? 1 : 0);
      chk("t2_owner", {31'd0, owner}, (k % 2 == 1) ? 1 : 0);
      if (k == 3) begin
        c_req = 0; d_req = 0;
      end
    end
    chk("t2_crdata", c_rdata, 8'hA5);
    chk("t2_drdata", d_rdata, 8'h77);
    tick();

    // MEM_LAT=3 debug read
    d_req3 = 1; d_addr3 = 5'h09;
    tick();
    chk("t5_men", {31'd0, m_en3}, 1);
    chk("t5_maddr", m_addr3, 5'h09);
    tick();
    chk("t5_men_off", {31'd0, m_en3}, 0);
    tick();
    chk("t5_dack_early", {31'd0, d_ack3}, 0);
    tick();
    chk("t5_dack", {31'd0, d_ack3}, 1);
    chk("t5_drdata", d_rdata3, 8'h99);
    chk("t5_cack", {31'd0, c_ack3}, 0);
    d_req3 = 0;
    tick();
    chk("t5_en_count", en3_cnt, 1);

`ifdef ARB_DBG_LOCK_EN
    // Lock: after one CPU grant, debug keeps the memory until d_lock drops
    d_lock = 1;
    c_req = 1; c_we = 0; c_addr = 5'h03;
    d_req = 1; d_we = 0; d_addr = 5'h07;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      chk("t6_gap", n, (k == 0) ? 2 : 3);
      chk("t6_dack", {31'd0, d_ack}, (k == 0 || k == 4) ? 0 : 1);
      if (k == 3) d_lock = 0;
      if (k == 4) begin
        c_req = 0; d_req = 0;
      end
    end
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
